// File: rtl/single_cycle_control_unit.sv
// single_cycle_control_unit
// Instruction decoder plus next-PC / hazard controller for the single-cycle
// RV32I core. Decodes the decode-stage opcode into datapath controls and
// picks the next PC from JAL / JALR / branch redirects and memory stalls.
// Optional debug trace: define CONTROL_UNIT_SCAN_EN to add a cycle counter
// and per-cycle $display of the control state while scan is high.
module single_cycle_control_unit #(
    parameter int CORE            = 0,
    parameter int ADDRESS_BITS    = 20,
    parameter int NUM_BYTES       = 4,
    parameter int LOG2_NUM_BYTES  = 2,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [6:0]                opcode_decode,
    input  logic [6:0]                opcode_execute,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  logic [ADDRESS_BITS-1:0]   JALR_target_execute,
    input  logic [ADDRESS_BITS-1:0]   branch_target_execute,
    input  logic [ADDRESS_BITS-1:0]   JAL_target_decode,
    input  logic                      branch_execute,
    input  logic                      fetch_valid,
    input  logic                      fetch_ready,
    input  logic [ADDRESS_BITS-1:0]   issue_PC,
    input  logic [ADDRESS_BITS-1:0]   fetch_address_in,
    input  logic                      memory_valid,
    input  logic                      memory_ready,
    input  logic                      load_memory,
    input  logic                      store_memory,
    input  logic [ADDRESS_BITS-1:0]   load_address,
    input  logic [ADDRESS_BITS-1:0]   memory_address_in,
    output logic                      branch_op,
    output logic                      memRead,
    output logic [5:0]                ALU_operation,
    output logic                      memWrite,
    output logic [LOG2_NUM_BYTES-1:0] log2_bytes,
    output logic                      unsigned_load,
    output logic [1:0]                next_PC_sel,
    output logic [1:0]                operand_A_sel,
    output logic                      operand_B_sel,
    output logic [1:0]                extend_sel,
    output logic                      regWrite,
    output logic [ADDRESS_BITS-1:0]   target_PC,
    output logic                      i_mem_read,
    output logic                      flush_fetch_receive,
    input  logic                      scan
);

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic fetchHazard;
    logic dmemHazard;
    logic jalrExecute;
    logic branchTaken;
    logic jalDecode;
    logic redirect;

    // Signals that only matter to the optional trace build, or are unused by design.
    logic unused_inputs;
    logic unused_params;
    assign unused_inputs = &{1'b0, clock, scan, fetch_ready, load_address,
                             memory_address_in, funct7[6], funct7[4:0]};
    assign unused_params = (CORE == 0) ^ (NUM_BYTES == 0) ^
                           (SCAN_CYCLES_MIN == 0) ^ (SCAN_CYCLES_MAX == 0);

    assign fetchHazard = ~fetch_valid | (fetch_address_in != issue_PC);
    assign dmemHazard  = ((load_memory | store_memory) & ~memory_ready) |
                         (load_memory & ~memory_valid);
    assign jalrExecute = (opcode_execute == OP_JALR);
    assign branchTaken = (opcode_execute == OP_BRANCH) & branch_execute;
    assign jalDecode   = (opcode_decode == OP_JAL);
    assign redirect    = jalrExecute | branchTaken | jalDecode;

    assign flush_fetch_receive = fetchHazard & ~reset;
    assign i_mem_read          = ~reset;

    // Decode the decode-stage instruction into datapath controls; state-changing enables are held low in reset.
    always_comb begin
        branch_op     = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        unsigned_load = 1'b0;
        regWrite      = 1'b0;
        operand_B_sel = 1'b0;
        ALU_operation = 6'd0;
        log2_bytes    = '0;
        operand_A_sel = 2'b00;
        extend_sel    = 2'b00;
        case (opcode_decode)
            OP_R_TYPE: begin
                ALU_operation = {2'b00, funct7[5], funct3};
                regWrite      = 1'b1;
            end
            OP_I_ALU: begin
                ALU_operation = {2'b00, (funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                operand_B_sel = 1'b1;
                regWrite      = 1'b1;
            end
            OP_LOAD: begin
                memRead       = 1'b1;
                operand_B_sel = 1'b1;
                regWrite      = 1'b1;
                log2_bytes    = LOG2_NUM_BYTES'(funct3[1:0]);
                unsigned_load = funct3[2];
            end
            OP_STORE: begin
                memWrite      = 1'b1;
                operand_B_sel = 1'b1;
                extend_sel    = 2'b01;
                log2_bytes    = LOG2_NUM_BYTES'(funct3[1:0]);
            end
            OP_BRANCH: begin
                branch_op     = 1'b1;
                ALU_operation = {3'b010, funct3};
            end
            OP_JAL, OP_JALR: begin
                ALU_operation = 6'b011111;
                operand_A_sel = 2'b10;
                regWrite      = 1'b1;
            end
            OP_LUI: begin
                operand_A_sel = 2'b11;
                operand_B_sel = 1'b1;
                extend_sel    = 2'b10;
                regWrite      = 1'b1;
            end
            OP_AUIPC: begin
                operand_A_sel = 2'b01;
                operand_B_sel = 1'b1;
                extend_sel    = 2'b10;
                regWrite      = 1'b1;
            end
            default: begin
                ALU_operation = 6'd0;
            end
        endcase
        if (reset) begin
            regWrite  = 1'b0;
            memRead   = 1'b0;
            memWrite  = 1'b0;
            branch_op = 1'b0;
        end
    end

    // Pick the next PC: a data-memory stall beats redirects, which beat fetch stalls.
    always_comb begin
        next_PC_sel = 2'b00;
        target_PC   = '0;
        if (!reset) begin
            if (jalrExecute) begin
                target_PC = JALR_target_execute;
            end else if (branchTaken) begin
                target_PC = branch_target_execute;
            end else if (jalDecode) begin
                target_PC = JAL_target_decode;
            end
            if (dmemHazard) begin
                next_PC_sel = 2'b01;
            end else if (redirect) begin
                next_PC_sel = 2'b10;
            end else if (fetchHazard) begin
                next_PC_sel = 2'b01;
            end
        end
    end

`ifdef CONTROL_UNIT_SCAN_EN
    logic [31:0] cycle_q;
    logic [31:0] cycle_d;

    // Free-running cycle counter used to window the trace output.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
    end

    // Advance the cycle counter, clearing it on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= 32'd0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    // Print the control state each cycle while tracing is enabled and inside the window.
    always_ff @(posedge clock) begin
        if (scan && (cycle_q >= $unsigned(SCAN_CYCLES_MIN)) && (cycle_q <= $unsigned(SCAN_CYCLES_MAX))) begin
            $display("------ Core %0d Control Unit - Current Cycle %0d ------", CORE, cycle_q);
            $display("| Opcode decode   [%b]", opcode_decode);
            $display("| Opcode execute  [%b]", opcode_execute);
            $display("| Next PC select  [%b]", next_PC_sel);
            $display("| Target PC       [%h]", target_PC);
            $display("| Fetch hazard    [%b]", fetchHazard);
            $display("| Memory hazard   [%b]", dmemHazard);
            $display("| Load address    [%h]", load_address);
            $display("| Memory address  [%h]", memory_address_in);
            $display("----------------------------------------------------------------------");
        end
    end
`endif

endmodule

// File: tb/tb_single_cycle_control_unit.sv
// tb_single_cycle_control_unit
// Directed scoreboard bench for single_cycle_control_unit: each step drives
// inputs, queues the expected output values, then pops and compares them.
module tb_single_cycle_control_unit;

    localparam int AB = 20;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_NONE   = 7'b0000000;

    typedef enum int {
        SIG_NEXTSEL, SIG_TARGET, SIG_FLUSH, SIG_IMEM, SIG_REGWR, SIG_MEMRD,
        SIG_MEMWR, SIG_BROP, SIG_ALU, SIG_BSEL, SIG_ASEL, SIG_EXT, SIG_LOG2, SIG_UNS
    } sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] value;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    logic          clock = 1'b0;
    logic          reset;
    logic [6:0]    opcode_decode, opcode_execute;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [AB-1:0] JALR_target_execute, branch_target_execute, JAL_target_decode;
    logic          branch_execute, fetch_valid, fetch_ready;
    logic [AB-1:0] issue_PC, fetch_address_in;
    logic          memory_valid, memory_ready, load_memory, store_memory;
    logic [AB-1:0] load_address, memory_address_in;
    logic          branch_op, memRead, memWrite, unsigned_load, regWrite, operand_B_sel;
    logic [5:0]    ALU_operation;
    logic [1:0]    log2_bytes;
    logic [1:0]    next_PC_sel, operand_A_sel, extend_sel;
    logic [AB-1:0] target_PC;
    logic          i_mem_read, flush_fetch_receive, scan;

    single_cycle_control_unit #(
        .CORE(0), .ADDRESS_BITS(AB), .NUM_BYTES(4), .LOG2_NUM_BYTES(2),
        .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
    ) dut (
        .clock(clock), .reset(reset),
        .opcode_decode(opcode_decode), .opcode_execute(opcode_execute),
        .funct3(funct3), .funct7(funct7),
        .JALR_target_execute(JALR_target_execute),
        .branch_target_execute(branch_target_execute),
        .JAL_target_decode(JAL_target_decode),
        .branch_execute(branch_execute),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .issue_PC(issue_PC), .fetch_address_in(fetch_address_in),
        .memory_valid(memory_valid), .memory_ready(memory_ready),
        .load_memory(load_memory), .store_memory(store_memory),
        .load_address(load_address), .memory_address_in(memory_address_in),
        .branch_op(branch_op), .memRead(memRead), .ALU_operation(ALU_operation),
        .memWrite(memWrite), .log2_bytes(log2_bytes), .unsigned_load(unsigned_load),
        .next_PC_sel(next_PC_sel), .operand_A_sel(operand_A_sel),
        .operand_B_sel(operand_B_sel), .extend_sel(extend_sel),
        .regWrite(regWrite), .target_PC(target_PC), .i_mem_read(i_mem_read),
        .flush_fetch_receive(flush_fetch_receive), .scan(scan)
    );

    // Free-running clock; the DUT's outputs are combinational so it only paces the steps.
    always #5 clock = ~clock;

    function automatic logic [31:0] observed(sig_e s);
        case (s)
            SIG_NEXTSEL: return {30'd0, next_PC_sel};
            SIG_TARGET:  return {12'd0, target_PC};
            SIG_FLUSH:   return {31'd0, flush_fetch_receive};
            SIG_IMEM:    return {31'd0, i_mem_read};
            SIG_REGWR:   return {31'd0, regWrite};
            SIG_MEMRD:   return {31'd0, memRead};
            SIG_MEMWR:   return {31'd0, memWrite};
            SIG_BROP:    return {31'd0, branch_op};
            SIG_ALU:     return {26'd0, ALU_operation};
            SIG_BSEL:    return {31'd0, operand_B_sel};
            SIG_ASEL:    return {30'd0, operand_A_sel};
            SIG_EXT:     return {30'd0, extend_sel};
            SIG_LOG2:    return {30'd0, log2_bytes};
            SIG_UNS:     return {31'd0, unsigned_load};
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expectSig(input string tag, input sig_e sig, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.sig   = sig;
        e.value = value;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus();
        @(negedge clock);
        reset                 = 1'b0;
        opcode_decode         = OP_R_TYPE;
        opcode_execute        = OP_NONE;
        funct3                = 3'b000;
        funct7                = 7'b0000000;
        JALR_target_execute   = 20'd4;
        branch_target_execute = 20'd8;
        JAL_target_decode     = 20'd12;
        branch_execute        = 1'b0;
        fetch_valid           = 1'b1;
        fetch_ready           = 1'b1;
        issue_PC              = 20'd0;
        fetch_address_in      = 20'd0;
        memory_valid          = 1'b1;
        memory_ready          = 1'b1;
        load_memory           = 1'b0;
        store_memory          = 1'b0;
        load_address          = 20'h00100;
        memory_address_in     = 20'h00100;
        scan                  = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observed(e.sig);
            total++;
            assert (obs === e.value) else begin
                bad++;
                $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.value);
            end
        end
    endtask

    initial begin
        // Reset: JAL in decode and fetch invalid, yet everything stays quiet.
        applyStimulus();
        reset = 1'b1; opcode_decode = OP_JAL; fetch_valid = 1'b0;
        expectSig("rst_sel", SIG_NEXTSEL, 32'd0);
        expectSig("rst_target", SIG_TARGET, 32'd0);
        expectSig("rst_flush", SIG_FLUSH, 32'd0);
        expectSig("rst_imem", SIG_IMEM, 32'd0);
        expectSig("rst_regwr", SIG_REGWR, 32'd0);
        checkOutput();

        // Reset with STORE decode, taken branch and a dmem stall.
        applyStimulus();
        reset = 1'b1; opcode_decode = OP_STORE; opcode_execute = OP_BRANCH;
        branch_execute = 1'b1; store_memory = 1'b1; memory_ready = 1'b0;
        expectSig("rst2_sel", SIG_NEXTSEL, 32'd0);
        expectSig("rst2_target", SIG_TARGET, 32'd0);
        expectSig("rst2_memwr", SIG_MEMWR, 32'd0);
        checkOutput();

        // Reset with LOAD then BRANCH in decode.
        applyStimulus();
        reset = 1'b1; opcode_decode = OP_LOAD;
        expectSig("rst_memrd", SIG_MEMRD, 32'd0);
        checkOutput();
        applyStimulus();
        reset = 1'b1; opcode_decode = OP_BRANCH;
        expectSig("rst_brop", SIG_BROP, 32'd0);
        checkOutput();

        // Idle R-type ADD after reset.
        applyStimulus();
        expectSig("idle_sel", SIG_NEXTSEL, 32'd0);
        expectSig("idle_target", SIG_TARGET, 32'd0);
        expectSig("idle_flush", SIG_FLUSH, 32'd0);
        expectSig("idle_imem", SIG_IMEM, 32'd1);
        expectSig("add_regwr", SIG_REGWR, 32'd1);
        expectSig("add_alu", SIG_ALU, 32'h00);
        expectSig("add_bsel", SIG_BSEL, 32'd0);
        expectSig("add_asel", SIG_ASEL, 32'd0);
        checkOutput();

        // Fetch hazards.
        applyStimulus();
        fetch_valid = 1'b0;
        expectSig("fvalid_sel", SIG_NEXTSEL, 32'd1);
        expectSig("fvalid_flush", SIG_FLUSH, 32'd1);
        checkOutput();
        applyStimulus();
        fetch_address_in = 20'd4;
        expectSig("faddr_sel", SIG_NEXTSEL, 32'd1);
        expectSig("faddr_flush", SIG_FLUSH, 32'd1);
        checkOutput();

        // Data-memory hazards.
        applyStimulus();
        store_memory = 1'b1; memory_ready = 1'b0;
        expectSig("store_stall_sel", SIG_NEXTSEL, 32'd1);
        expectSig("store_stall_flush", SIG_FLUSH, 32'd0);
        checkOutput();
        applyStimulus();
        load_memory = 1'b1; memory_valid = 1'b0;
        expectSig("load_stall_sel", SIG_NEXTSEL, 32'd1);
        expectSig("load_stall_target", SIG_TARGET, 32'd0);
        checkOutput();
        applyStimulus();
        load_memory = 1'b1;
        expectSig("load_ok_sel", SIG_NEXTSEL, 32'd0);
        checkOutput();

        // Redirects.
        applyStimulus();
        opcode_decode = OP_JAL;
        expectSig("jal_target", SIG_TARGET, 32'd12);
        expectSig("jal_sel", SIG_NEXTSEL, 32'd2);
        expectSig("jal_alu", SIG_ALU, 32'h1F);
        expectSig("jal_asel", SIG_ASEL, 32'd2);
        expectSig("jal_regwr", SIG_REGWR, 32'd1);
        checkOutput();
        applyStimulus();
        opcode_execute = OP_JALR;
        expectSig("jalr_target", SIG_TARGET, 32'd4);
        expectSig("jalr_sel", SIG_NEXTSEL, 32'd2);
        checkOutput();
        applyStimulus();
        opcode_execute = OP_JALR; opcode_decode = OP_JAL;
        expectSig("jalr_over_jal_target", SIG_TARGET, 32'd4);
        checkOutput();
        applyStimulus();
        opcode_execute = OP_BRANCH;
        expectSig("br_nt_target", SIG_TARGET, 32'd0);
        expectSig("br_nt_sel", SIG_NEXTSEL, 32'd0);
        checkOutput();
        applyStimulus();
        opcode_execute = OP_BRANCH; branch_execute = 1'b1;
        expectSig("br_t_target", SIG_TARGET, 32'd8);
        expectSig("br_t_sel", SIG_NEXTSEL, 32'd2);
        checkOutput();
        applyStimulus();
        opcode_execute = OP_BRANCH; branch_execute = 1'b1; opcode_decode = OP_JAL;
        expectSig("br_over_jal_target", SIG_TARGET, 32'd8);
        checkOutput();
        applyStimulus();
        opcode_execute = OP_BRANCH; branch_execute = 1'b1; load_memory = 1'b1; memory_valid = 1'b0;
        expectSig("stall_over_br_sel", SIG_NEXTSEL, 32'd1);
        expectSig("stall_over_br_target", SIG_TARGET, 32'd8);
        checkOutput();
        applyStimulus();
        opcode_execute = OP_BRANCH; branch_execute = 1'b1; fetch_valid = 1'b0;
        expectSig("br_over_fetch_sel", SIG_NEXTSEL, 32'd2);
        expectSig("br_over_fetch_flush", SIG_FLUSH, 32'd1);
        checkOutput();

        // Decode checks.
        applyStimulus();
        opcode_decode = OP_LOAD; funct3 = 3'b100;
        expectSig("lbu_memrd", SIG_MEMRD, 32'd1);
        expectSig("lbu_log2", SIG_LOG2, 32'd0);
        expectSig("lbu_uns", SIG_UNS, 32'd1);
        expectSig("lbu_bsel", SIG_BSEL, 32'd1);
        expectSig("lbu_regwr", SIG_REGWR, 32'd1);
        checkOutput();
        applyStimulus();
        opcode_decode = OP_LOAD; funct3 = 3'b010;
        expectSig("lw_log2", SIG_LOG2, 32'd2);
        expectSig("lw_uns", SIG_UNS, 32'd0);
        checkOutput();
        applyStimulus();
        funct7 = 7'b0100000;
        expectSig("sub_alu", SIG_ALU, 32'h08);
        expectSig("sub_regwr", SIG_REGWR, 32'd1);
        checkOutput();
        applyStimulus();
        opcode_decode = OP_I_ALU; funct3 = 3'b101; funct7 = 7'b0100000;
        expectSig("srai_alu", SIG_ALU, 32'h0D);
        expectSig("srai_bsel", SIG_BSEL, 32'd1);
        expectSig("srai_ext", SIG_EXT, 32'd0);
        checkOutput();
        applyStimulus();
        opcode_decode = OP_I_ALU; funct3 = 3'b000; funct7 = 7'b0100000;
        expectSig("addi_f7_alu", SIG_ALU, 32'h00);
        checkOutput();
        applyStimulus();
        opcode_decode = OP_STORE; funct3 = 3'b010;
        expectSig("sw_memwr", SIG_MEMWR, 32'd1);
        expectSig("sw_regwr", SIG_REGWR, 32'd0);
        expectSig("sw_ext", SIG_EXT, 32'd1);
        expectSig("sw_log2", SIG_LOG2, 32'd2);
        expectSig("sw_bsel", SIG_BSEL, 32'd1);
        checkOutput();
        applyStimulus();
        opcode_decode = OP_BRANCH; funct3 = 3'b001;
        expectSig("bne_brop", SIG_BROP, 32'd1);
        expectSig("bne_alu", SIG_ALU, 32'h11);
        expectSig("bne_bsel", SIG_BSEL, 32'd0);
        expectSig("bne_regwr", SIG_REGWR, 32'd0);
        checkOutput();
        applyStimulus();
        opcode_decode = OP_JALR;
        expectSig("jalr_dec_alu", SIG_ALU, 32'h1F);
        expectSig("jalr_dec_asel", SIG_ASEL, 32'd2);
        expectSig("jalr_dec_sel", SIG_NEXTSEL, 32'd0);
        checkOutput();
        applyStimulus();
        opcode_decode = OP_LUI;
        expectSig("lui_asel", SIG_ASEL, 32'd3);
        expectSig("lui_ext", SIG_EXT, 32'd2);
        expectSig("lui_bsel", SIG_BSEL, 32'd1);
        expectSig("lui_regwr", SIG_REGWR, 32'd1);
        checkOutput();
        applyStimulus();
        opcode_decode = OP_AUIPC;
        expectSig("auipc_asel", SIG_ASEL, 32'd1);
        expectSig("auipc_ext", SIG_EXT, 32'd2);
        expectSig("auipc_alu", SIG_ALU, 32'h00);
        checkOutput();
        applyStimulus();
        opcode_decode = 7'b1111111; funct3 = 3'b111; funct7 = 7'b0100000;
        expectSig("bad_op_regwr", SIG_REGWR, 32'd0);
        expectSig("bad_op_memrd", SIG_MEMRD, 32'd0);
        expectSig("bad_op_memwr", SIG_MEMWR, 32'd0);
        expectSig("bad_op_brop", SIG_BROP, 32'd0);
        expectSig("bad_op_alu", SIG_ALU, 32'h00);
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
